pwm_seq_ctrl: RTL and testbench
===============================

Name: pwm_seq_ctrl

Overview:
Sequencer between the AXI register bank and the six PWM generator channels (control words 12..17). It owns the per-channel control word the generators see. On a global go it resets the selected channels, then enables them one at a time with a programmable stagger. While running it applies software duty/divider changes only at each channel's period boundary (glitch-free), and on halt it shuts channels down at period end.

Parameters:
N_CH, 6, number of PWM channels sequenced
STAGGER_W, 16, width of stagger delay count
RST_CYC, 4, cycles channel reset is held during startup (>=1)
STOP_TO, 1024, max cycles to wait for period_done before forcing a channel off

Ports:
clk_axi  in  1  system clock, same domain as register bank
rst  in  1  synchronous, active-high reset
go  in  1  level from register bit; rising edge starts a sequence
halt  in  1  level; rising edge requests stop
ch_mask  in  N_CH  channels taking part in the sequence
stagger_cyc  in  STAGGER_W  cycles between successive channel enables
cfg_in  in  N_CH*10  software words per channel: [2:0] div, [5:3] duty, [7] load request
period_done  in  N_CH  1-cycle pulse from each generator at end of period
cfg_out  out  N_CH*10  words to generators: [2:0] div, [5:3] duty, [6] 0, [7] load pulse, [8] ch reset, [9] ch enable
ch_running  out  N_CH  channel enable currently asserted
busy  out  1  state != IDLE
state_o  out  2  IDLE=0, STARTRST=1, STAGGER=2, RUN=3 (STOP reported as 3 with busy)
err  out  1  sticky: go with empty mask, or STOP timeout; cleared by next accepted go

Behaviour:
- Reset (rst=1 at clock edge): all cfg_out bits 0, ch_running=0, busy=0, err=0, state IDLE, shadows cleared, edge detectors armed with current input values so no false edge after reset. Applies mid-sequence as well: everything drops in the same cycle.
- go/halt/cfg_in[7] are edge-detected (registered previous value). An edge sampled at edge T acts at T+1.
- IDLE: go edge with ch_mask!=0 -> latch ch_mask and stagger_cyc, capture div/duty of all channels into shadow and active copies -> STARTRST. go edge with ch_mask==0 -> set err, stay IDLE.
- STARTRST: rst bit [8]=1 on masked channels for exactly RST_CYC cycles, en=0. Then -> STAGGER.
- STAGGER: enable masked channels in ascending index order. First enable in the cycle after STARTRST ends. Each next masked channel is enabled max(stagger_cyc,1) cycles after the previous one. Unmasked indices take no time. The cycle after the last enable -> RUN.
- RUN: cfg_in[7] rising edge on channel i -> capture div/duty into shadow i, set pending i. On period_done[i] with pending i set, copy shadow to active, assert load bit [7] for exactly that one cycle (same edge), clear pending. If an edge and period_done coincide, the new value captures and stays pending until the next period_done. A second edge before apply overwrites the shadow (last write wins). Load requests outside RUN are ignored.
- halt edge in STARTRST/STAGGER: all en/rst drop next cycle -> IDLE.
- halt edge in RUN -> STOP: each running channel drops en on its next period_done. A channel with no period_done within STOP_TO cycles is forced off and err is set. When ch_running==0 -> IDLE.
- go edges while busy are ignored. halt has priority over a same-cycle go.
- Unmasked channels: cfg_out word all 0 throughout.
- Widths: stagger counter STAGGER_W bits, no wrap (compare then reload). STOP timeout counter clog2(STOP_TO+1) bits, saturating.

Decomposition:
- pwm_seq_pkg: state enum, cfg word bit-position constants (DIV_LSB=0, DUTY_LSB=3, LOAD_BIT=7, RST_BIT=8, EN_BIT=9), CFG_W=10.
- Sub-module pwm_ch_shadow, one instance per channel: edge detect, shadow/active regs, pending flag, load pulse, stop-on-period_done logic. Top holds the FSM, stagger counter and timeout counter.

Test Plan:
- ch_mask=6'h3F, stagger_cyc=5, go edge at T -> rst bits high T+1..T+4, ch0 en at T+5, ch1 at T+10, … ch5 at T+30, state RUN at T+31.
- ch_mask=6'b100101, stagger_cyc=0 -> ch0, ch2, ch5 enabled on 3 consecutive cycles. ch1/3/4 words stay 0.
- RUN, ch2 div=3'b010 duty=3'b100 with load edge, period_done[2] 7 cycles later -> cfg_out ch2 updates and load pulse high only in that cycle. A coincident new load edge stays pending until the next period_done.
- halt in RUN with ch3 never pulsing period_done, STOP_TO=1024 -> others drop at their period_done, ch3 forced off at 1024 cycles, err=1, IDLE.
- go with ch_mask=0 -> err=1, busy stays 0. A following valid go clears err.
- rst asserted mid-STAGGER -> next cycle all cfg_out=0, busy=0. A held-high go does not restart without a new rising edge.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM channel sequencer.
// - state_e     : sequencer FSM states
// - CFG_W       : width of one per-channel control word
// - *_LSB/*_BIT : bit positions inside a control word
package pwm_seq_pkg;

  localparam int unsigned CFG_W    = 10;
  localparam int unsigned FIELD_W  = 3;
  localparam int unsigned DIV_LSB  = 0;
  localparam int unsigned DUTY_LSB = 3;
  localparam int unsigned LOAD_BIT = 7;
  localparam int unsigned RST_BIT  = 8;
  localparam int unsigned EN_BIT   = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStartRst,
    StStagger,
    StRun,
    StStop
  } state_e;

  // STOP is reported externally with the RUN code; busy tells them apart.
  function automatic logic [1:0] state_code(input state_e s);
    logic [1:0] code;
    code = 2'd0;
    unique case (s)
      StIdle:     code = 2'd0;
      StStartRst: code = 2'd1;
      StStagger:  code = 2'd2;
      StRun:      code = 2'd3;
      StStop:     code = 2'd3;
      default:    code = 2'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pwm_ch_shadow.sv
// Per-channel shadow/active control word holder.
// - clk_i, rst_i       : clock, synchronous active-high reset
// - start_i            : sequence accepted; capture div/duty into shadow and active, clear state
// - run_i, stop_i      : sequencer is in RUN / STOP
// - en_set_i, en_clr_i : enable this channel / force it off
// - rst_bit_i          : channel reset bit to place in the output word
// - div_duty_i, ld_i   : software div/duty and load request level
// - period_done_i      : end-of-period pulse from the generator
// - word_o, en_o       : control word to the generator, enable state
module pwm_ch_shadow
  import pwm_seq_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 run_i,
  input  logic                 stop_i,
  input  logic                 en_set_i,
  input  logic                 en_clr_i,
  input  logic                 rst_bit_i,
  input  logic [2*FIELD_W-1:0] div_duty_i,
  input  logic                 ld_i,
  input  logic                 period_done_i,
  output logic [CFG_W-1:0]     word_o,
  output logic                 en_o
);

  logic                 ld_prev_q;
  logic [2*FIELD_W-1:0] shadow_q, shadow_d;
  logic [2*FIELD_W-1:0] active_q, active_d;
  logic                 pend_q, pend_d;
  logic                 load_q, load_d;
  logic                 en_q, en_d;
  logic                 capture, apply;

  always_comb begin
    capture  = run_i & ld_i & ~ld_prev_q;
    apply    = run_i & period_done_i & pend_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    load_d   = 1'b0;
    en_d     = en_q;
    if (start_i) begin
      shadow_d = div_duty_i;
      active_d = div_duty_i;
      pend_d   = 1'b0;
      en_d     = 1'b0;
    end else begin
      // Apply uses the old shadow; a coincident capture stays pending.
      if (apply) active_d = shadow_q;
      if (capture) shadow_d = div_duty_i;
      pend_d = capture | (pend_q & ~apply);
      load_d = apply;
      if (en_clr_i) begin
        en_d = 1'b0;
      end else if (en_set_i) begin
        en_d = 1'b1;
      end else if (stop_i && period_done_i) begin
        en_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // Edge detector tracks the input even in reset so no false edge follows it.
    ld_prev_q <= ld_i;
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      load_q   <= load_d;
      en_q     <= en_d;
    end
  end

  always_comb begin
    word_o                             = '0;
    word_o[DIV_LSB +: 2*FIELD_W]       = active_q;
    word_o[LOAD_BIT]                   = load_q;
    word_o[RST_BIT]                    = rst_bit_i;
    word_o[EN_BIT]                     = en_q;
  end

  assign en_o = en_q;

endmodule

// File: rtl/pwm_seq_ctrl.sv
// PWM channel startup/shutdown sequencer.
// - clk_axi, rst            : clock, synchronous active-high reset
// - go, halt                : levels; rising edges start / stop a sequence
// - ch_mask, stagger_cyc    : channels taking part, cycles between enables
// - cfg_in                  : software words per channel (div, duty, load request)
// - period_done             : end-of-period pulses from the generators
// - cfg_out                 : control words to the generators
// - ch_running, busy        : per-channel enable, sequencer not idle
// - state_o, err            : external state code, sticky error
module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter int unsigned N_CH      = 6,
  parameter int unsigned STAGGER_W = 16,
  parameter int unsigned RST_CYC   = 4,
  parameter int unsigned STOP_TO   = 1024
) (
  input  logic                  clk_axi,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  halt,
  input  logic [N_CH-1:0]       ch_mask,
  input  logic [STAGGER_W-1:0]  stagger_cyc,
  input  logic [N_CH*CFG_W-1:0] cfg_in,
  input  logic [N_CH-1:0]       period_done,
  output logic [N_CH*CFG_W-1:0] cfg_out,
  output logic [N_CH-1:0]       ch_running,
  output logic                  busy,
  output logic [1:0]            state_o,
  output logic                  err
);

  localparam int unsigned RstCntW = $clog2(RST_CYC + 1);
  localparam int unsigned ToW     = $clog2(STOP_TO + 1);

  state_e               state_q, state_d;
  logic                 go_q, halt_q;
  logic [N_CH-1:0]      mask_q, mask_d;
  logic [STAGGER_W-1:0] stagger_q, stagger_d;
  logic [N_CH-1:0]      wait_q, wait_d;
  logic [RstCntW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [STAGGER_W-1:0] stg_cnt_q, stg_cnt_d;
  logic [ToW-1:0]       to_cnt_q, to_cnt_d;
  logic                 err_q, err_d;

  logic                 go_edge, halt_edge, start, en_clr;
  logic [N_CH-1:0]      en_set, mask_low, wait_low;
  logic [STAGGER_W-1:0] stg_target;

  assign go_edge    = go & ~go_q;
  assign halt_edge  = halt & ~halt_q;
  assign mask_low   = mask_q & (~mask_q + N_CH'(1));
  assign wait_low   = wait_q & (~wait_q + N_CH'(1));
  assign stg_target = (stagger_q == '0) ? STAGGER_W'(1) : stagger_q;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    stagger_d = stagger_q;
    wait_d    = wait_q;
    rst_cnt_d = rst_cnt_q;
    stg_cnt_d = stg_cnt_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    start     = 1'b0;
    en_set    = '0;
    en_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // halt wins over a coincident go
        if (go_edge && !halt_edge) begin
          if (ch_mask != '0) begin
            mask_d    = ch_mask;
            stagger_d = stagger_cyc;
            rst_cnt_d = '0;
            err_d     = 1'b0;
            start     = 1'b1;
            state_d   = StStartRst;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StStartRst: begin
        if (halt_edge) begin
          en_clr  = 1'b1;
          state_d = StIdle;
        end else if (rst_cnt_q == RstCntW'(RST_CYC - 1)) begin
          // First enable lands in the cycle right after reset ends.
          en_set    = mask_low;
          wait_d    = mask_q & ~mask_low;
          stg_cnt_d = STAGGER_W'(1);
          state_d   = StStagger;
        end else begin
          rst_cnt_d = rst_cnt_q + RstCntW'(1);
        end
      end
      StStagger: begin
        if (halt_edge) begin
          en_clr  = 1'b1;
          state_d = StIdle;
        end else if (wait_q == '0) begin
          state_d = StRun;
        end else if (stg_cnt_q >= stg_target) begin
          en_set    = wait_low;
          wait_d    = wait_q & ~wait_low;
          stg_cnt_d = STAGGER_W'(1);
        end else begin
          stg_cnt_d = stg_cnt_q + STAGGER_W'(1);
        end
      end
      StRun: begin
        if (halt_edge) begin
          to_cnt_d = '0;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (ch_running == '0) begin
          state_d = StIdle;
        end else if (to_cnt_q == ToW'(STOP_TO - 1)) begin
          en_clr = 1'b1;
          err_d  = 1'b1;
        end
        if (to_cnt_q != ToW'(STOP_TO)) to_cnt_d = to_cnt_q + ToW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_axi) begin
    go_q   <= go;
    halt_q <= halt;
    if (rst) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      stagger_q <= '0;
      wait_q    <= '0;
      rst_cnt_q <= '0;
      stg_cnt_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      stagger_q <= stagger_d;
      wait_q    <= wait_d;
      rst_cnt_q <= rst_cnt_d;
      stg_cnt_q <= stg_cnt_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CFG_W-1:0] word;
    logic             unused_cfg;

    // Bits 6, 8 and 9 of the software word carry nothing.
    assign unused_cfg = ^{cfg_in[i*CFG_W+6], cfg_in[i*CFG_W+RST_BIT], cfg_in[i*CFG_W+EN_BIT]};

    pwm_ch_shadow u_shadow (
      .clk_i         (clk_axi),
      .rst_i         (rst),
      .start_i       (start),
      .run_i         (state_q == StRun),
      .stop_i        (state_q == StStop),
      .en_set_i      (en_set[i]),
      .en_clr_i      (en_clr),
      .rst_bit_i     ((state_q == StStartRst) && mask_q[i]),
      .div_duty_i    (cfg_in[i*CFG_W+DIV_LSB +: 2*FIELD_W]),
      .ld_i          (cfg_in[i*CFG_W+LOAD_BIT]),
      .period_done_i (period_done[i]),
      .word_o        (word),
      .en_o          (ch_running[i])
    );

    assign cfg_out[i*CFG_W +: CFG_W] = mask_q[i] ? word : '0;
  end

  assign busy    = (state_q != StIdle);
  assign state_o = state_code(state_q);
  assign err     = err_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
module tb_pwm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, go, halt;
  logic [5:0]  ch_mask;
  logic [15:0] stagger_cyc;
  logic [59:0] cfg_in;
  logic [5:0]  period_done;
  logic [59:0] cfg_out;
  logic [5:0]  ch_running;
  logic        busy;
  logic [1:0]  state_o;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  // Expected active div/duty per channel, maintained by hand alongside stimulus.
  logic [2:0] act_div  [6];
  logic [2:0] act_duty [6];

  pwm_seq_ctrl #(
    .N_CH      (6),
    .STAGGER_W (16),
    .RST_CYC   (4),
    .STOP_TO   (1024)
  ) dut (
    .clk_axi     (clk),
    .rst         (rst),
    .go          (go),
    .halt        (halt),
    .ch_mask     (ch_mask),
    .stagger_cyc (stagger_cyc),
    .cfg_in      (cfg_in),
    .period_done (period_done),
    .cfg_out     (cfg_out),
    .ch_running  (ch_running),
    .busy        (busy),
    .state_o     (state_o),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [9:0] word(input int ch, input logic ld, input logic rb, input logic en);
    return {en, rb, ld, 1'b0, act_duty[ch], act_div[ch]};
  endfunction

  function automatic logic [59:0] all_words(input logic [5:0] m, input logic rb,
                                            input logic [5:0] en);
    logic [59:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*10 +: 10] = m[i] ? word(i, 1'b0, rb, en[i]) : 10'd0;
    return r;
  endfunction

  task automatic set_cfg(input int ch, input logic [2:0] dv, input logic [2:0] dt,
                         input logic ld);
    cfg_in[ch*10 +: 10] = {2'b00, ld, 1'b0, dt, dv};
  endtask

  initial begin
    int n;
    int exp_n;
    logic [5:0] exp_run;
    int exp_st;

    rst = 1'b1; go = 1'b0; halt = 1'b0; ch_mask = '0; stagger_cyc = '0;
    cfg_in = '0; period_done = '0;
    for (int i = 0; i < 6; i++) begin
      act_div[i]  = 3'(i);
      act_duty[i] = 3'(7 - i);
      set_cfg(i, act_div[i], act_duty[i], 1'b0);
    end
    tick(2);
    check("rst_cfg_out", cfg_out, 60'd0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_state", state_o, 0);
    rst = 1'b0;
    tick();

    // Full mask, stagger 5
    ch_mask = 6'h3F; stagger_cyc = 16'd5; go = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k < 5) exp_n = 0;
      else exp_n = ((k - 5) / 5 + 1 > 6) ? 6 : (k - 5) / 5 + 1;
      exp_run = 6'((1 << exp_n) - 1);
      exp_st  = (k <= 4) ? 1 : ((k <= 30) ? 2 : 3);
      check($sformatf("t1_state_k%0d", k), state_o, exp_st);
      check($sformatf("t1_run_k%0d", k), ch_running, exp_run);
      if (k == 1 || k == 4) check("t1_rst_words", cfg_out, all_words(6'h3F, 1'b1, 6'h00));
      if (k == 5) check("t1_first_en", cfg_out, all_words(6'h3F, 1'b0, 6'h01));
      if (k == 31) check("t1_run_words", cfg_out, all_words(6'h3F, 1'b0, 6'h3F));
    end

    // Glitch-free load on ch2
    set_cfg(2, 3'b010, 3'b100, 1'b1);
    tick();
    set_cfg(2, 3'b010, 3'b100, 1'b0);
    tick(5);
    check("ld_hold", cfg_out[20 +: 10], word(2, 1'b0, 1'b0, 1'b1));
    period_done = 6'b000100;
    tick();
    period_done = '0;
    act_div[2] = 3'b010; act_duty[2] = 3'b100;
    check("ld_apply", cfg_out[20 +: 10], word(2, 1'b1, 1'b0, 1'b1));
    tick();
    check("ld_pulse_end", cfg_out[20 +: 10], word(2, 1'b0, 1'b0, 1'b1));

    // Pending A, then new edge B coincident with period_done
    set_cfg(2, 3'b001, 3'b110, 1'b1);
    tick();
    set_cfg(2, 3'b001, 3'b110, 1'b0);
    tick();
    set_cfg(2, 3'b101, 3'b011, 1'b1);
    period_done = 6'b000100;
    tick();
    set_cfg(2, 3'b101, 3'b011, 1'b0);
    period_done = '0;
    act_div[2] = 3'b001; act_duty[2] = 3'b110;
    check("co_apply_a", cfg_out[20 +: 10], word(2, 1'b1, 1'b0, 1'b1));
    tick();
    check("co_hold_b", cfg_out[20 +: 10], word(2, 1'b0, 1'b0, 1'b1));
    period_done = 6'b000100;
    tick();
    period_done = '0;
    act_div[2] = 3'b101; act_duty[2] = 3'b011;
    check("co_apply_b", cfg_out[20 +: 10], word(2, 1'b1, 1'b0, 1'b1));
    period_done = 6'b000001;
    tick();
    period_done = '0;
    check("no_pend_no_load", cfg_out[0 +: 10], word(0, 1'b0, 1'b0, 1'b1));

    // Halt with ch3 silent -> timeout
    halt = 1'b1;
    tick();
    n = 1;
    check("stop_state", state_o, 3);
    check("stop_busy", busy, 1);
    period_done = 6'b110111;
    tick();
    n++;
    period_done = '0;
    check("stop_pd_drop", ch_running, 6'b001000);
    while (ch_running[3] && n < 2000) begin
      tick();
      n++;
    end
    check("stop_timeout_cyc", n, 1025);
    check("stop_err", err, 1);
    tick();
    check("stop_idle_state", state_o, 0);
    check("stop_idle_busy", busy, 0);
    halt = 1'b0;

    // Sparse mask, stagger 0
    go = 1'b0;
    tick();
    ch_mask = 6'b100101; stagger_cyc = 16'd0; go = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) check("t2_err_clr", err, 0);
      exp_run = (k <= 4) ? 6'b000000 : (k == 5) ? 6'b000001 : (k == 6) ? 6'b000101 : 6'b100101;
      exp_st  = (k <= 4) ? 1 : ((k <= 7) ? 2 : 3);
      check($sformatf("t2_state_k%0d", k), state_o, exp_st);
      check($sformatf("t2_run_k%0d", k), ch_running, exp_run);
      check($sformatf("t2_unmasked_k%0d", k), {cfg_out[10 +: 10], cfg_out[30 +: 10],
                                             cfg_out[40 +: 10]}, 30'd0);
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    period_done = 6'b100101;
    tick();
    period_done = '0;
    check("t2_stop_run", ch_running, 0);
    tick();
    check("t2_stop_idle", state_o, 0);

    // Empty mask go
    go = 1'b0;
    tick();
    ch_mask = '0; go = 1'b1;
    tick();
    check("empty_err", err, 1);
    check("empty_busy", busy, 0);
    go = 1'b0;
    tick();
    ch_mask = 6'h3F; stagger_cyc = 16'd2; go = 1'b1;
    tick();
    check("valid_go_err_clr", err, 0);
    check("valid_go_state", state_o, 1);

    // Reset mid-STAGGER with go held high
    tick(6);
    check("mid_stagger_state", state_o, 2);
    rst = 1'b1;
    tick();
    check("mid_rst_cfg", cfg_out, 60'd0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_run", ch_running, 0);
    check("mid_rst_state", state_o, 0);
    rst = 1'b0;
    tick(3);
    check("held_go_no_restart", busy, 0);
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    check("new_go_restart", state_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
